// File: rtl/parking_exit_if.sv
// Bundle of the fill/exit/payment vectors and per-gate status between the
// parking_exit controller and its environment.
interface parking_exit_if #(
  parameter int SPOTS      = 64,
  parameter int EXIT_GATES = 2,
  parameter int FEE_W      = 12
);
  localparam int SW = $clog2(SPOTS);

  logic [SPOTS-1:0]                 car_parked_spots;
  logic [SPOTS-1:0]                 exit_req;
  logic [EXIT_GATES-1:0]            gate_pay_ack;
  logic [SPOTS-1:0]                 car_exiting_spots;
  logic [EXIT_GATES-1:0]            gate_fee_valid;
  logic [EXIT_GATES-1:0][FEE_W-1:0] gate_fee;
  logic [EXIT_GATES-1:0][SW-1:0]    gate_spot;
  logic [EXIT_GATES-1:0]            gate_open;
  logic [SPOTS-1:0]                 occupied;

  modport master (
    output car_parked_spots, exit_req, gate_pay_ack,
    input  car_exiting_spots, gate_fee_valid, gate_fee, gate_spot, gate_open, occupied
  );

  modport slave (
    input  car_parked_spots, exit_req, gate_pay_ack,
    output car_exiting_spots, gate_fee_valid, gate_fee, gate_spot, gate_open, occupied
  );
endinterface

// File: rtl/parking_exit.sv
// Departure controller: occupancy and arrival stamps, exit-request capture,
// fixed-priority gate arbitration and one billing FSM per exit gate.
module parking_exit #(
  parameter int SPOTS       = 64,
  parameter int EXIT_GATES  = 2,
  parameter int TIME_W      = 16,
  parameter int FEE_W       = 12,
  parameter int RATE_SHIFT  = 4,
  parameter int OPEN_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  parking_exit_if.slave bus
);
  localparam int SW = $clog2(SPOTS);
  localparam int CW = $clog2(OPEN_CYCLES + 1);
  localparam logic [TIME_W:0] FEE_MAX = (TIME_W+1)'((1 << FEE_W) - 1);

  // state     | meaning
  // S_IDLE    | free, claims lowest pending spot
  // S_BILL    | computes and registers the fee
  // S_WAIT_PAY| fee presented, waiting for pay ack
  // S_OPEN    | barrier open, down-counter running
  // S_RELEASE | release pulse out, spot freed at end
  typedef enum logic [2:0] {S_IDLE, S_BILL, S_WAIT_PAY, S_OPEN, S_RELEASE} state_t;

  state_t                           state_q [EXIT_GATES];
  state_t                           state_d [EXIT_GATES];
  logic [EXIT_GATES-1:0][SW-1:0]    spot_q, spot_d;
  logic [EXIT_GATES-1:0][FEE_W-1:0] fee_q, fee_d;
  logic [EXIT_GATES-1:0][CW-1:0]    cnt_q, cnt_d;
  logic [TIME_W-1:0]                now_q, now_d;
  logic [TIME_W-1:0]                stamp_q [SPOTS];
  logic [TIME_W-1:0]                stamp_d [SPOTS];
  logic [SPOTS-1:0]                 occupied_q, occupied_d;
  logic [SPOTS-1:0]                 pending_q, pending_d;
  logic [SPOTS-1:0]                 exiting_q, exiting_d;

  logic [SPOTS-1:0]  served, release_mask, taken;
  logic [TIME_W-1:0] elapsed;
  logic [TIME_W:0]   fee_wide;
  logic              found;

  always_comb begin
    now_d        = now_q + TIME_W'(1);
    stamp_d      = stamp_q;
    exiting_d    = '0;
    served       = '0;
    release_mask = '0;
    taken        = '0;
    elapsed      = '0;
    fee_wide     = '0;
    found        = 1'b0;

    for (int i = 0; i < SPOTS; i++) begin
      if (bus.car_parked_spots[i]) stamp_d[i] = now_q;
    end

    for (int g = 0; g < EXIT_GATES; g++) begin
      if (state_q[g] != S_IDLE)    served[spot_q[g]] = 1'b1;
      if (state_q[g] == S_RELEASE) release_mask[spot_q[g]] = 1'b1;
    end

    for (int g = 0; g < EXIT_GATES; g++) begin
      state_d[g] = state_q[g];
      spot_d[g]  = spot_q[g];
      fee_d[g]   = fee_q[g];
      cnt_d[g]   = cnt_q[g];
      case (state_q[g])
        S_IDLE: begin
          // lower gates have already marked their claims in taken
          found = 1'b0;
          for (int i = 0; i < SPOTS; i++) begin
            if (!found && pending_q[i] && !taken[i]) begin
              found      = 1'b1;
              taken[i]   = 1'b1;
              spot_d[g]  = SW'(i);
              state_d[g] = S_BILL;
            end
          end
        end
        S_BILL: begin
          elapsed    = now_q - stamp_q[spot_q[g]];
          fee_wide   = {1'b0, elapsed >> RATE_SHIFT} + (TIME_W+1)'(1);
          fee_d[g]   = (fee_wide > FEE_MAX) ? '1 : fee_wide[FEE_W-1:0];
          state_d[g] = S_WAIT_PAY;
        end
        S_WAIT_PAY: begin
          if (bus.gate_pay_ack[g]) begin
            state_d[g] = S_OPEN;
            cnt_d[g]   = CW'(OPEN_CYCLES - 1);
          end
        end
        S_OPEN: begin
          if (cnt_q[g] == '0) begin
            state_d[g]           = S_RELEASE;
            exiting_d[spot_q[g]] = 1'b1;
          end else begin
            cnt_d[g] = cnt_q[g] - CW'(1);
          end
        end
        S_RELEASE: state_d[g] = S_IDLE;
        default:   state_d[g] = S_IDLE;
      endcase
    end

    occupied_d = (occupied_q & ~release_mask) | bus.car_parked_spots;
    pending_d  = (pending_q & ~taken)
               | (bus.exit_req & occupied_q & ~pending_q & ~served & ~bus.car_parked_spots);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      now_q      <= '0;
      occupied_q <= '0;
      pending_q  <= '0;
      exiting_q  <= '0;
      spot_q     <= '0;
      fee_q      <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < SPOTS; i++)      stamp_q[i] <= '0;
      for (int g = 0; g < EXIT_GATES; g++) state_q[g] <= S_IDLE;
    end else begin
      now_q      <= now_d;
      occupied_q <= occupied_d;
      pending_q  <= pending_d;
      exiting_q  <= exiting_d;
      spot_q     <= spot_d;
      fee_q      <= fee_d;
      cnt_q      <= cnt_d;
      for (int i = 0; i < SPOTS; i++)      stamp_q[i] <= stamp_d[i];
      for (int g = 0; g < EXIT_GATES; g++) state_q[g] <= state_d[g];
    end
  end

  always_comb begin
    bus.gate_fee_valid = '0;
    bus.gate_open      = '0;
    for (int g = 0; g < EXIT_GATES; g++) begin
      bus.gate_fee_valid[g] = (state_q[g] == S_WAIT_PAY);
      bus.gate_open[g]      = (state_q[g] == S_OPEN);
    end
  end

  assign bus.car_exiting_spots = exiting_q;
  assign bus.occupied          = occupied_q;
  assign bus.gate_fee          = fee_q;
  assign bus.gate_spot         = spot_q;
endmodule

// File: tb/tb_parking_exit.sv
// Directed bench for parking_exit: billing, arbitration, illegal requests,
// fee wrap/saturation and asynchronous reset abort.
module tb_parking_exit;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   tnow    = 0;
  int   pulse_cnt [64];

  always #5 clk = ~clk;

  parking_exit_if bus ();

  parking_exit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one cycle; tnow tracks the DUT time counter after reset release
  task automatic tick();
    @(posedge clk);
    #1;
    tnow++;
    for (int i = 0; i < 64; i++) if (bus.car_exiting_spots[i] === 1'b1) pulse_cnt[i]++;
  endtask

  task automatic wait_until(input int t);
    while (tnow < t) tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) pulse_cnt[i] = 0;
    bus.car_parked_spots = '0;
    bus.exit_req         = '0;
    bus.gate_pay_ack     = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_occupied", bus.occupied, 64'h0);
    chk("rst_exiting",  bus.car_exiting_spots, 64'h0);
    chk("rst_valid",    64'(bus.gate_fee_valid), 64'h0);
    chk("rst_open",     64'(bus.gate_open), 64'h0);
    chk("rst_fee",      64'(bus.gate_fee), 64'h0);
    chk("rst_spot",     64'(bus.gate_spot), 64'h0);
    rst_n = 1'b1;
    tnow  = 0;

    // single car on spot 5
    wait_until(10);
    bus.car_parked_spots[5] = 1'b1;
    tick();
    bus.car_parked_spots = '0;
    chk("t1_occ5", 64'(bus.occupied[5]), 64'h1);
    wait_until(61);
    bus.car_parked_spots[40] = 1'b1;
    tick();
    bus.car_parked_spots = '0;
    wait_until(110);
    bus.exit_req[5] = 1'b1;
    tick();
    bus.exit_req = '0;
    chk("t1_valid_early", 64'(bus.gate_fee_valid), 64'h0);
    wait_until(113);
    chk("t1_valid", 64'(bus.gate_fee_valid), 64'h1);
    chk("t1_fee",   64'(bus.gate_fee[0]), 64'd7);
    chk("t1_spot",  64'(bus.gate_spot[0]), 64'd5);
    tick();
    chk("t1_fee_stable", 64'(bus.gate_fee[0]), 64'd7);
    tick();
    bus.gate_pay_ack[0] = 1'b1;
    tick();
    bus.gate_pay_ack = '0;
    chk("t1_open_a",  64'(bus.gate_open), 64'h1);
    chk("t1_valid_0", 64'(bus.gate_fee_valid), 64'h0);
    tick();
    chk("t1_open_b", 64'(bus.gate_open), 64'h1);
    tick();
    chk("t1_open_c", 64'(bus.gate_open), 64'h1);
    tick();
    chk("t1_open_end", 64'(bus.gate_open), 64'h0);
    chk("t1_release",  bus.car_exiting_spots, 64'h20);
    chk("t1_occ_hold", 64'(bus.occupied[5]), 64'h1);
    tick();
    chk("t1_release_end", bus.car_exiting_spots, 64'h0);
    chk("t1_occ_clr",     64'(bus.occupied[5]), 64'h0);
    chk("t1_fee_hold",    64'(bus.gate_fee[0]), 64'd7);

    // two gates, three requests
    wait_until(130);
    bus.car_parked_spots = 64'h0010_0208;
    tick();
    bus.car_parked_spots = '0;
    bus.exit_req = 64'h0010_0208;
    tick();
    bus.exit_req = '0;
    wait_until(134);
    chk("t2_valid", 64'(bus.gate_fee_valid), 64'h3);
    chk("t2_spot0", 64'(bus.gate_spot[0]), 64'd3);
    chk("t2_spot1", 64'(bus.gate_spot[1]), 64'd9);
    chk("t2_fee0",  64'(bus.gate_fee[0]), 64'd1);
    bus.exit_req[3]     = 1'b1;
    bus.gate_pay_ack[1] = 1'b1;
    tick();
    bus.gate_pay_ack = '0;
    chk("t2_open1", 64'(bus.gate_open), 64'h2);
    tick();
    bus.exit_req = '0;
    wait_until(138);
    chk("t2_rel9", bus.car_exiting_spots, 64'h200);
    wait_until(141);
    chk("t2_spot20",  64'(bus.gate_spot[1]), 64'd20);
    chk("t2_valid20", 64'(bus.gate_fee_valid), 64'h3);
    chk("t2_fee20",   64'(bus.gate_fee[1]), 64'd1);
    bus.gate_pay_ack[0] = 1'b1;
    tick();
    bus.gate_pay_ack = 2'b10;
    tick();
    bus.gate_pay_ack = '0;
    wait_until(150);
    chk("t2_cnt3",   64'(pulse_cnt[3]), 64'd1);
    chk("t2_cnt9",   64'(pulse_cnt[9]), 64'd1);
    chk("t2_cnt20",  64'(pulse_cnt[20]), 64'd1);
    chk("t2_occ",    bus.occupied & 64'h0010_0208, 64'h0);
    chk("t2_idle",   64'(bus.gate_fee_valid), 64'h0);
    chk("t2_hold0",  64'(bus.gate_spot[0]), 64'd3);

    // request on an empty spot
    bus.exit_req[7] = 1'b1;
    tick();
    bus.exit_req = '0;
    wait_until(154);
    chk("t3_valid", 64'(bus.gate_fee_valid), 64'h0);
    chk("t3_open",  64'(bus.gate_open), 64'h0);
    chk("t3_occ7",  64'(bus.occupied[7]), 64'h0);

    // park and request in the same cycle
    wait_until(160);
    bus.car_parked_spots[4] = 1'b1;
    bus.exit_req[4]         = 1'b1;
    tick();
    bus.car_parked_spots = '0;
    bus.exit_req         = '0;
    wait_until(165);
    chk("t4_occ4",  64'(bus.occupied[4]), 64'h1);
    chk("t4_valid", 64'(bus.gate_fee_valid), 64'h0);

    // wrap and saturation: both bills land at now=60 after the wrap
    wait_until(65530);
    bus.car_parked_spots[50] = 1'b1;
    tick();
    bus.car_parked_spots = '0;
    wait_until(65594);
    bus.exit_req = (64'h1 << 40) | (64'h1 << 50);
    tick();
    bus.exit_req = '0;
    wait_until(65597);
    chk("t5_valid", 64'(bus.gate_fee_valid), 64'h3);
    chk("t5_spot0", 64'(bus.gate_spot[0]), 64'd40);
    chk("t5_sat",   64'(bus.gate_fee[0]), 64'd4095);
    chk("t5_spot1", 64'(bus.gate_spot[1]), 64'd50);
    chk("t5_wrap",  64'(bus.gate_fee[1]), 64'd5);

    // reset while gate 0 is open
    bus.gate_pay_ack[0] = 1'b1;
    tick();
    bus.gate_pay_ack = '0;
    chk("t6_open", 64'(bus.gate_open), 64'h1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_open_rst",  64'(bus.gate_open), 64'h0);
    chk("t6_valid_rst", 64'(bus.gate_fee_valid), 64'h0);
    chk("t6_occ_rst",   bus.occupied, 64'h0);
    chk("t6_fee_rst",   64'(bus.gate_fee), 64'h0);
    chk("t6_exit_rst",  bus.car_exiting_spots, 64'h0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("t6_no_rel40", 64'(pulse_cnt[40]), 64'd0);
    chk("t6_no_rel50", 64'(pulse_cnt[50]), 64'd0);
    chk("t6_occ_after", bus.occupied, 64'h0);
    chk("t6_open_after", 64'(bus.gate_open), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/parking_exit.md
Name: parking_exit

Overview:
- Departure-side controller for the parking lot. It is the producer of the `car_exiting_spots` vector that the spot allocator consumes.
- Tracks which spots are occupied and timestamps each arrival.
- Accepts exit requests from spots and arbitrates them onto a small number of exit gates.
- Each gate bills the car, waits for a payment handshake, opens the barrier, then releases the spot with a one-cycle pulse.

Parameters:
- SPOTS, 64: number of parking spots.
- EXIT_GATES, 2: number of exit gates, each with an independent FSM.
- TIME_W, 16: width of the free-running time counter and of the per-spot arrival stamps.
- FEE_W, 12: fee output width; fee saturates at 2^FEE_W-1.
- RATE_SHIFT, 4: elapsed cycles are divided by 2^RATE_SHIFT to give fee units.
- OPEN_CYCLES, 3: number of cycles the barrier is held open.

Ports:
- clock, in, 1: single clock, rising-edge.
- reset, in, 1: asynchronous, active-low reset.
- car_parked_spots, in, SPOTS: spots filled this cycle (the allocator's fill vector).
- exit_req, in, SPOTS: per-spot exit request, sampled every cycle.
- gate_pay_ack, in, EXIT_GATES: per-gate payment accepted.
- car_exiting_spots, out, SPOTS: registered one-cycle release pulse per spot.
- gate_fee_valid, out, EXIT_GATES: fee is presented and awaiting payment.
- gate_fee, out, EXIT_GATES x FEE_W: fee for the car currently at each gate.
- gate_spot, out, EXIT_GATES x $clog2(SPOTS): spot index being served by each gate.
- gate_open, out, EXIT_GATES: barrier open.
- occupied, out, SPOTS: current occupancy (1 = occupied).

Behaviour:
- Reset (asynchronous, active-low) forces all of the following to 0: occupied, pending, stamps, time counter, every gate FSM (to IDLE), and every output. Asserting reset mid-transaction aborts it; no release pulse is emitted.
- Time counter `now`:
  - Increments every cycle and wraps modulo 2^TIME_W.
  - When `car_parked_spots[i]` is high, the next edge sets `occupied[i]` and sets `stamp[i]` to the current `now`.
- Exit request capture:
  - A request sets `pending[i]` on the next edge only if `occupied[i]`=1, `pending[i]`=0 and spot i is not being served by any gate. Otherwise it is dropped.
  - If `car_parked_spots[i]` and `exit_req[i]` are high in the same cycle, parking is applied and the request is dropped.
- Arbitration:
  - Each cycle, IDLE gates are taken in ascending gate index.
  - Gate g takes the lowest-indexed pending spot not already claimed by a lower-numbered gate in the same cycle.
  - The claimed spot's `pending` bit is cleared and its index latched into `gate_spot[g]`.
  - Two gates never hold the same spot.
- Gate FSM, with per-state behaviour:
  - IDLE → BILL when a spot is claimed.
  - BILL (one cycle):
    - elapsed = (now − stamp[spot]) mod 2^TIME_W.
    - fee = (elapsed >> RATE_SHIFT) + 1, saturated at 2^FEE_W−1.
    - Fee is registered into `gate_fee`. → WAIT_PAY.
  - WAIT_PAY: `gate_fee_valid`=1 and `gate_fee` stays stable. When `gate_pay_ack`=1 → OPEN. An ack is ignored in every other state.
  - OPEN: `gate_open`=1 for exactly OPEN_CYCLES cycles, counted by a down-counter. Then → RELEASE.
  - RELEASE (one cycle):
    - `car_exiting_spots[spot]`=1, registered.
    - `occupied[spot]` clears on the same edge that ends RELEASE.
    - → IDLE. A new claim is possible in the cycle after RELEASE.
- Latency:
  - exit_req in cycle t: pending at t+1, BILL at t+2, fee_valid at t+3.
  - pay_ack in cycle p: gate_open from p+1 to p+OPEN_CYCLES, release pulse at p+OPEN_CYCLES+1.
- Release pulses from different gates may coincide; their bits OR together.
- Unused outputs:
  - `gate_fee` and `gate_spot` hold their last value when IDLE.
  - `gate_fee_valid` and `gate_open` are 0 outside their states.
- `exit_req` for a spot that is releasing in the same cycle is dropped.

Test Plan:
- Single car:
  - Stimulus: park spot 5 at now=10; exit_req[5] at now=110; pay_ack two cycles after fee_valid.
  - Required: BILL at now=112, so elapsed=102 and gate_fee=7 on gate 0. gate_open for 3 cycles. car_exiting_spots=64'h20 for one cycle. occupied[5] clears.
- Two gates: spots 3, 9 and 20 occupied; exit_req on all three in the same cycle.
  - Gate 0 takes 3 and gate 1 takes 9. Spot 20 stays pending.
  - Spot 20 is claimed by the first gate to return to IDLE.
- Illegal requests:
  - exit_req[7] with spot 7 empty: no pending, no gate activity.
  - Repeated exit_req[3] while spot 3 is in WAIT_PAY: ignored, spot 3 is released exactly once.
- Saturation and wrap:
  - Stamp at now=65530, billed after the counter wraps to now=60: elapsed=66, fee=5.
  - Elapsed of 65535 with FEE_W=12: fee=4095.
- Simultaneity: car_parked_spots[4] and exit_req[4] in the same cycle → spot 4 is occupied and no pending bit is set.
- Reset mid-operation: drive reset low while gate 0 is in OPEN → gate_open and all outputs go to 0 immediately (asynchronously) and occupied is cleared. No release pulse occurs after reset is released.
